hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles after a mult start.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles after a div start.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 d_rs_addr, d_rt_addr  in  5 each  D-stage source register numbers.
REQ-006 d_tuse_rs, d_tuse_rt  in  2 each  cycles until D-stage instruction needs rs/rt; 3 = not used.
REQ-007 e_wr_addr, m_wr_addr  in  5 each  destination register of E-stage and M-stage instructions.
REQ-008 e_tnew, m_tnew  in  2 each  cycles until E/M result is forwardable; 0 = available now.
REQ-009 d_is_md  in  1  D-stage instruction uses HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 e_md_start  in  1  E-stage instruction launches mult/div this cycle.
REQ-011 e_md_op  in  1  0 = mult, 1 = div; valid with e_md_start.
REQ-012 exc_req  in  1  M-stage exception/interrupt taken this cycle.
REQ-013 pc_en  out  1  PC write enable.
REQ-014 d_en  out  1  En of D-stage pipeline register.
REQ-015 e_clr  out  1  bubble-insert (E-register clear) request.
REQ-016 flush  out  1  flush to all pipeline registers.
REQ-017 md_busy  out  1  HI/LO unit busy.

Function
REQ-018 Data hazard on rs: d_rs_addr != 0 and ((e_wr_addr == d_rs_addr and e_tnew > d_tuse_rs) or (m_wr_addr == d_rs_addr and m_tnew > d_tuse_rs)); identically for rt.
REQ-019 Register 0 never causes a stall; d_tuse = 3 never causes a stall (tnew max is 2).
REQ-020 MD hazard: d_is_md and (md_busy or e_md_start).
REQ-021 stall = data hazard on rs or rt or MD hazard; combinational, same cycle.
REQ-022 pc_en = d_en = not stall; e_clr = stall and not exc_req.
REQ-023 flush = exc_req, combinational; flush overrides stall (pc_en, d_en, e_clr values are don't-care to registers while flush = 1, but e_clr shall be 0).
REQ-024 Busy counter: 4-bit, loads MULT_CYCLES or DIV_CYCLES per e_md_op on the clock edge where e_md_start = 1 and exc_req = 0; otherwise decrements by 1 if nonzero; holds at 0.
REQ-025 md_busy = (counter != 0), registered; first busy cycle is the cycle after e_md_start.
REQ-026 e_md_start with exc_req = 1 in the same cycle is ignored (counter not loaded).
REQ-027 A running count is not aborted by exc_req; it runs to 0.
REQ-028 e_md_start while counter nonzero reloads the counter (cannot occur in correct operation; defined for safety).
REQ-029 Stall during exc_req does not affect counter behaviour.

Reset
REQ-030 reset = 1 at a clock edge forces counter to 0; thereafter md_busy = 0.
REQ-031 Under reset, combinational outputs follow inputs; reset mid-count clears the count in one edge.

Structure
REQ-032 Shared package holds MULT_CYCLES, DIV_CYCLES defaults, TUSE_NONE = 3, and the 2-bit tuse/tnew width constant.
REQ-033 One sub-module md_busy_counter (clk, reset, start, op, exc, busy) contains the counter; hazard comparison stays in hazard_ctrl.

Verification
REQ-034 d_rs_addr=5, d_tuse_rs=0, e_wr_addr=5, e_tnew=1 -> pc_en=0, d_en=0, e_clr=1; change e_tnew=0 -> pc_en=1, e_clr=0.
REQ-035 d_rt_addr=0, e_wr_addr=0, e_tnew=2, d_tuse_rt=0 -> no stall; d_rs_addr=7, d_tuse_rs=3, m_wr_addr=7, m_tnew=2 -> no stall.
REQ-036 e_md_start=1, e_md_op=0 at edge T -> md_busy=1 for edges T+1..T+5, 0 at T+6; d_is_md=1 during that window -> stall each cycle, released when md_busy=0.
REQ-037 e_md_start=1, e_md_op=1, exc_req=1 same cycle -> flush=1, e_clr=0, md_busy stays 0.
REQ-038 Div started (count 10), reset=1 asserted at 4th busy cycle -> md_busy=0 next cycle; div restart afterward gives full 10 busy cycles.
REQ-039 Data stall active plus exc_req=1 -> flush=1, e_clr=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared constants for the hazard controller
package hazard_ctrl_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int T_W = 2;
  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter: HI/LO unit busy countdown loaded on mult/div start
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic exc,
  output logic busy
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    cnt <= reset ? 4'd0 : (start && !exc) ? (op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : cnt - 4'(cnt != 4'd0);
  assign busy = cnt != 4'd0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control from tuse/tnew data hazards and HI/LO busy
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     d_rs_addr,
  input  logic [4:0]     d_rt_addr,
  input  logic [T_W-1:0] d_tuse_rs,
  input  logic [T_W-1:0] d_tuse_rt,
  input  logic [4:0]     e_wr_addr,
  input  logic [4:0]     m_wr_addr,
  input  logic [T_W-1:0] e_tnew,
  input  logic [T_W-1:0] m_tnew,
  input  logic           d_is_md,
  input  logic           e_md_start,
  input  logic           e_md_op,
  input  logic           exc_req,
  output logic           pc_en,
  output logic           d_en,
  output logic           e_clr,
  output logic           flush,
  output logic           md_busy
);
  logic rs_haz, rt_haz, md_haz, stall;
  md_busy_counter #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_cnt (
    .clk(clk), .reset(reset), .start(e_md_start), .op(e_md_op), .exc(exc_req), .busy(md_busy)
  );
  always_comb begin
    rs_haz = d_rs_addr != 5'd0 && d_tuse_rs != TUSE_NONE &&
             ((e_wr_addr == d_rs_addr && e_tnew > d_tuse_rs) || (m_wr_addr == d_rs_addr && m_tnew > d_tuse_rs));
    rt_haz = d_rt_addr != 5'd0 && d_tuse_rt != TUSE_NONE &&
             ((e_wr_addr == d_rt_addr && e_tnew > d_tuse_rt) || (m_wr_addr == d_rt_addr && m_tnew > d_tuse_rt));
    md_haz = d_is_md && (md_busy || e_md_start);
    stall = rs_haz || rt_haz || md_haz;
    pc_en = !stall;
    d_en = !stall;
    e_clr = stall && !exc_req;
    flush = exc_req;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random plus directed checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] d_rs_addr, d_rt_addr, e_wr_addr, m_wr_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic d_is_md, e_md_start, e_md_op, exc_req;
  logic pc_en, d_en, e_clr, flush, md_busy;
  int checks = 0, failures = 0;
  int edge_n = 0, busy_end = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .e_wr_addr(e_wr_addr), .m_wr_addr(m_wr_addr),
    .e_tnew(e_tnew), .m_tnew(m_tnew), .d_is_md(d_is_md), .e_md_start(e_md_start),
    .e_md_op(e_md_op), .exc_req(exc_req), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
    .flush(flush), .md_busy(md_busy)
  );
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask
  function automatic bit src_haz(logic [4:0] a, logic [1:0] tuse);
    return a != 0 && tuse != 3 && ((a == e_wr_addr && e_tnew > tuse) || (a == m_wr_addr && m_tnew > tuse));
  endfunction
  // Model: the unit is busy while the edge count is below the end edge of the last accepted start.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (reset) busy_end <= 0;
    else if (e_md_start && !exc_req) busy_end <= edge_n + 1 + (e_md_op ? 10 : 5);
  end
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit exp_busy = edge_n < busy_end;
      automatic bit stall = src_haz(d_rs_addr, d_tuse_rs) || src_haz(d_rt_addr, d_tuse_rt) ||
                            (d_is_md && (exp_busy || e_md_start));
      chk("m_busy", md_busy, exp_busy);
      chk("m_pc_en", pc_en, !stall);
      chk("m_d_en", d_en, !stall);
      chk("m_e_clr", e_clr, stall && !exc_req);
      chk("m_flush", flush, exc_req);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reset = 0; d_rs_addr = 0; d_rt_addr = 0; e_wr_addr = 0; m_wr_addr = 0;
    d_tuse_rs = 3; d_tuse_rt = 3; e_tnew = 0; m_tnew = 0;
    d_is_md = 0; e_md_start = 0; e_md_op = 0; exc_req = 0;
  endtask
  initial begin
    int n;
    idle();
    reset = 1;
    cyc();
    cyc();
    chk_en = 1;
    reset = 0;
    #4 chk("rst_busy", md_busy, 0);
    cyc();
    d_rs_addr = 5; d_tuse_rs = 0; e_wr_addr = 5; e_tnew = 1;
    #4 chk("r34_pc", pc_en, 0); chk("r34_d", d_en, 0); chk("r34_clr", e_clr, 1);
    cyc();
    e_tnew = 0;
    #4 chk("r34b_pc", pc_en, 1); chk("r34b_clr", e_clr, 0);
    cyc();
    idle();
    e_wr_addr = 0; e_tnew = 2; d_tuse_rt = 0;
    #4 chk("r35_zero", pc_en, 1);
    cyc();
    idle();
    d_rs_addr = 7; d_tuse_rs = 3; m_wr_addr = 7; m_tnew = 2;
    #4 chk("r35_tuse3", pc_en, 1);
    cyc();
    idle();
    e_md_start = 1;
    cyc();
    idle();
    d_is_md = 1;
    for (int k = 1; k <= 6; k++) begin
      #4 chk("r36_busy", md_busy, k <= 5); chk("r36_pc", pc_en, k > 5);
      cyc();
    end
    idle();
    e_md_start = 1; e_md_op = 1; exc_req = 1;
    #4 chk("r37_flush", flush, 1); chk("r37_clr", e_clr, 0);
    cyc();
    idle();
    #4 chk("r37_busy", md_busy, 0);
    cyc();
    e_md_start = 1; e_md_op = 1;
    cyc();
    idle();
    for (int k = 1; k <= 3; k++) begin
      #4 chk("r38_busy", md_busy, 1);
      cyc();
    end
    #4 chk("r38_busy4", md_busy, 1);
    reset = 1;
    cyc();
    reset = 0;
    #4 chk("r38_rst", md_busy, 0);
    e_md_start = 1; e_md_op = 1;
    cyc();
    idle();
    n = 0;
    repeat (12) begin
      #4 if (md_busy) n++;
      cyc();
    end
    chk("r38_full", n, 10);
    d_rs_addr = 5; d_tuse_rs = 0; e_wr_addr = 5; e_tnew = 2; exc_req = 1;
    #4 chk("r39_flush", flush, 1); chk("r39_clr", e_clr, 0);
    cyc();
    repeat (3000) begin
      reset = $urandom_range(63) == 0;
      d_rs_addr = 5'($urandom_range(3)); d_rt_addr = 5'($urandom_range(3));
      e_wr_addr = 5'($urandom_range(3)); m_wr_addr = 5'($urandom_range(3));
      d_tuse_rs = 2'($urandom_range(3)); d_tuse_rt = 2'($urandom_range(3));
      e_tnew = 2'($urandom_range(2)); m_tnew = 2'($urandom_range(2));
      d_is_md = $urandom_range(3) == 0;
      e_md_start = $urandom_range(7) == 0;
      e_md_op = 1'($urandom_range(1));
      exc_req = $urandom_range(15) == 0;
      cyc();
    end
    idle();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
